// File: rtl/usys_pkg.sv
// Shared types and helpers for the unary systolic GEMM PE sequencers.
package usys_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLOAD  = 3'd1,
    ST_STREAM = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_DONE   = 3'd4
  } pe_seq_state_t;

  function automatic int unsigned stream_len(input int unsigned bw);
    return 32'd1 << bw;
  endfunction

  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r[5'(w - 1 - i)] = v[5'(i)];
      end else begin
        r[5'(i)] = r[5'(i)];
      end
    end
    return r;
  endfunction

  // Right-shifting Galois masks of maximal-length polynomials; 0 means unsupported width.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    logic [31:0] t;
    case (w)
      32'd2:   t = 32'h0000_0003;
      32'd3:   t = 32'h0000_0006;
      32'd4:   t = 32'h0000_000C;
      32'd5:   t = 32'h0000_0014;
      32'd6:   t = 32'h0000_0030;
      32'd7:   t = 32'h0000_0060;
      32'd8:   t = 32'h0000_00B8;
      32'd16:  t = 32'h0000_B400;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/usys_rng.sv
// Per-tile random-number source: binary up-counter by default, or a
// de Bruijn-augmented Galois LFSR when USYS_LFSR_RNG_EN is defined.
module usys_rng
  import usys_pkg::*;
#(
  parameter int unsigned BINARY_RANDOM_NUM_BITWIDTH = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  advance,
  output logic [BINARY_RANDOM_NUM_BITWIDTH-1:0] rand_num
);

  localparam int unsigned BW = BINARY_RANDOM_NUM_BITWIDTH;

  logic [BW-1:0] rand_q;
  logic [BW-1:0] rand_d;
  logic [BW-1:0] step_s;

`ifdef USYS_LFSR_RNG_EN
  localparam logic [BW-1:0] TAPS      = BW'(lfsr_taps(BW));
  localparam logic [BW-1:0] ZERO_PRED = BW'(2);

  // The plain LFSR maps 2 -> 1; splicing 0 in between gives a full 2^BW period.
  always_comb begin
    if (rand_q == {BW{1'b0}}) begin
      step_s = BW'(1);
    end else if (rand_q == ZERO_PRED) begin
      step_s = {BW{1'b0}};
    end else if (rand_q[0]) begin
      step_s = (rand_q >> 1'b1) ^ TAPS;
    end else begin
      step_s = rand_q >> 1'b1;
    end
  end
`else
  always_comb begin
    step_s = rand_q + BW'(1);
  end
`endif

  always_comb begin
    rand_d = rand_q;
    if (clear) begin
      rand_d = {BW{1'b0}};
    end else if (advance) begin
      rand_d = step_s;
    end else begin
      rand_d = rand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rand_q <= {BW{1'b0}};
    end else begin
      rand_q <= rand_d;
    end
  end

  assign rand_num = rand_q;

endmodule

// File: rtl/pe_inner_seq_ctrl.sv
// Tile sequencer for one PE_inner: weight load, unary stream, passby window.
// The RNG flavour is selected in usys_rng by USYS_LFSR_RNG_EN.
module pe_inner_seq_ctrl
  import usys_pkg::*;
#(
  parameter int unsigned BINARY_RANDOM_NUM_BITWIDTH = 3,
  parameter int unsigned ACC_CYCLES                 = 1,
  parameter int unsigned TILE_CNT_BITWIDTH          = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [TILE_CNT_BITWIDTH-1:0]          num_tiles,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  weight_reg_en,
  output logic                                  weight_reg_r0w1,
  output logic                                  input_reg_en,
  output logic                                  input_reg_r0w1,
  output logic                                  rand_num_reg_en,
  output logic                                  rand_num_reg_r0w1,
  output logic                                  output_num_reg_en,
  output logic                                  output_num_reg_r0w1,
  output logic [BINARY_RANDOM_NUM_BITWIDTH-1:0] b_w_rand_num_passby,
  output logic [BINARY_RANDOM_NUM_BITWIDTH-1:0] b_i_rand_num_passby,
  output logic                                  M_end
);

  localparam int unsigned BW         = BINARY_RANDOM_NUM_BITWIDTH;
  localparam int unsigned TW         = TILE_CNT_BITWIDTH;
  localparam int unsigned STREAM_LEN = stream_len(BW);
  localparam int unsigned ACC_W      = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(STREAM_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(ACC_CYCLES - 1);

  pe_seq_state_t state_q;
  pe_seq_state_t state_d;

  logic [TW-1:0]    tiles_q;
  logic [TW-1:0]    tiles_d;
  logic [BW-1:0]    beat_q;
  logic [BW-1:0]    beat_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  logic          start_ok_s;
  logic          w_fire_s;
  logic          beat_s;
  logic          last_beat_s;
  logic          acc_last_s;
  logic [BW-1:0] rng_val_s;

  always_comb begin
    start_ok_s  = (state_q == ST_IDLE) && start;
    w_fire_s    = (state_q == ST_WLOAD) && w_valid;
    beat_s      = (state_q == ST_STREAM) && in_valid;
    last_beat_s = beat_s && (beat_q == LAST_BEAT);
    acc_last_s  = (state_q == ST_ACCUM) && (acc_q == ACC_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d = (num_tiles != {TW{1'b0}}) ? ST_WLOAD : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WLOAD: begin
        state_d = w_fire_s ? ST_STREAM : ST_WLOAD;
      end
      ST_STREAM: begin
        state_d = last_beat_s ? ST_ACCUM : ST_STREAM;
      end
      ST_ACCUM: begin
        if (acc_last_s) begin
          // tiles_q still holds the count before this tile is retired.
          state_d = (tiles_q == TW'(1)) ? ST_DONE : ST_WLOAD;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tiles_d = tiles_q;
    if (start_ok_s && (num_tiles != {TW{1'b0}})) begin
      tiles_d = num_tiles;
    end else if (acc_last_s) begin
      tiles_d = tiles_q - TW'(1);
    end else begin
      tiles_d = tiles_q;
    end

    beat_d = beat_q;
    if (w_fire_s) begin
      beat_d = {BW{1'b0}};
    end else if (beat_s) begin
      beat_d = beat_q + BW'(1);
    end else begin
      beat_d = beat_q;
    end

    acc_d = acc_q;
    if (state_q == ST_ACCUM) begin
      acc_d = acc_q + ACC_W'(1);
    end else begin
      acc_d = {ACC_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tiles_q <= {TW{1'b0}};
      beat_q  <= {BW{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
    end else begin
      tiles_q <= tiles_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
    end
  end

  // Strobes follow the state, gated by the feeder valid only where a handshake completes.
  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    w_ready             = 1'b0;
    in_ready            = 1'b0;
    weight_reg_en       = 1'b0;
    weight_reg_r0w1     = 1'b0;
    input_reg_en        = 1'b0;
    input_reg_r0w1      = 1'b0;
    rand_num_reg_en     = 1'b0;
    rand_num_reg_r0w1   = 1'b0;
    output_num_reg_en   = 1'b0;
    output_num_reg_r0w1 = 1'b0;
    M_end               = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_WLOAD: begin
        busy            = 1'b1;
        w_ready         = 1'b1;
        weight_reg_en   = w_valid;
        weight_reg_r0w1 = w_valid;
      end
      ST_STREAM: begin
        busy              = 1'b1;
        in_ready          = 1'b1;
        input_reg_en      = in_valid;
        input_reg_r0w1    = in_valid;
        rand_num_reg_en   = in_valid;
        rand_num_reg_r0w1 = in_valid;
        M_end             = last_beat_s;
      end
      ST_ACCUM: begin
        busy                = 1'b1;
        output_num_reg_en   = 1'b1;
        output_num_reg_r0w1 = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  usys_rng #(
    .BINARY_RANDOM_NUM_BITWIDTH(BW)
  ) u_rng (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_fire_s),
    .advance (beat_s),
    .rand_num(rng_val_s)
  );

  assign b_w_rand_num_passby = rng_val_s;
  assign b_i_rand_num_passby = BW'(bit_reverse(32'(rng_val_s), BW));

endmodule
